// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-width high pulses separated by a
// guaranteed low gap, queuing events that arrive while a pulse is running.
module pulse_stretcher #(
  parameter int WIDTH  = 8,
  parameter int GAP    = 2,
  parameter int QDEPTH = 3,
  parameter int CW     = 4
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       Trigger,
  output logic       Stretched,
  output logic       Busy,
  output logic [1:0] Pending,
  output logic       Dropped
);

  typedef enum logic [1:0] {StIdle, StHigh, StGap} stateT;

  stateT         state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [1:0]    pendNext;
  logic          lastGap, deq, directStart, enq, full, acceptEnq, dropNow;

  // Queue bookkeeping: a dequeue frees a slot in the same cycle, so a trigger
  // landing on the last gap cycle is accepted even when the queue is full.
  always_comb begin
    lastGap     = (state == StGap) && (cnt == '0);
    deq         = lastGap && (Pending != 2'd0);
    directStart = lastGap && (Pending == 2'd0) && Trigger;
    enq         = Trigger && (state != StIdle) && !directStart;
    full        = (Pending == 2'(QDEPTH));
    acceptEnq   = enq && (!full || deq);
    dropNow     = enq && full && !deq;

    stateNext = state;
    cntNext   = cnt;
    case (state)
      StIdle: begin
        if (Trigger) begin
          stateNext = StHigh;
          cntNext   = CW'(WIDTH - 1);
        end
      end
      StHigh: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else begin
          stateNext = StGap;
          cntNext   = CW'(GAP - 1);
        end
      end
      StGap: begin
        if (cnt != '0) begin
          cntNext = cnt - CW'(1);
        end else if (deq || directStart) begin
          stateNext = StHigh;
          cntNext   = CW'(WIDTH - 1);
        end else begin
          stateNext = StIdle;
        end
      end
      default: begin
        stateNext = StIdle;
        cntNext   = '0;
      end
    endcase

    pendNext = Pending;
    if (acceptEnq && !deq)
      pendNext = Pending + 2'd1;
    else if (deq && !acceptEnq)
      pendNext = Pending - 2'd1;
  end

  // Outputs are decoded from the next state so they line up with it and
  // never depend combinationally on Trigger.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state     <= StIdle;
      cnt       <= '0;
      Pending   <= 2'd0;
      Stretched <= 1'b0;
      Busy      <= 1'b0;
      Dropped   <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      Pending   <= pendNext;
      Stretched <= (stateNext == StHigh);
      Busy      <= (stateNext != StIdle) || (pendNext != 2'd0);
      Dropped   <= dropNow;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher: directed scenarios plus random triggers,
// compared every cycle against a timeline-based reference model.
module tb_pulse_stretcher;

  localparam int W  = 4;
  localparam int G  = 2;
  localparam int Q  = 2;
  localparam int CW = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic       stretched;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int rises  = 0;
  logic prevStr = 1'b0;

  // Reference model: a pulse is described by the edge it started on, so
  // high/gap phases follow from elapsed time alone.
  bit mActive = 1'b0;
  int mStart  = 0;
  int mPend   = 0;
  bit mDrop   = 1'b0;

  always #5 clock = ~clock;

  pulse_stretcher #(.WIDTH(W), .GAP(G), .QDEPTH(Q), .CW(CW)) dut (
    .CLOCK    (clock),
    .Reset    (reset),
    .Trigger  (trigger),
    .Stretched(stretched),
    .Busy     (busy),
    .Pending  (pending),
    .Dropped  (dropped)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic modelStep(input bit trig, input bit rst);
    int pos;
    mDrop = 1'b0;
    if (rst) begin
      mActive = 1'b0;
      mPend   = 0;
    end else if (!mActive) begin
      if (trig) begin
        mActive = 1'b1;
        mStart  = cycle;
      end
    end else begin
      pos = cycle - mStart - 1;
      if (pos == W + G - 1) begin
        if (mPend > 0) begin
          mPend--;
          mStart = cycle;
          if (trig) mPend++;
        end else if (trig) begin
          mStart = cycle;
        end else begin
          mActive = 1'b0;
        end
      end else if (trig) begin
        if (mPend < Q) mPend++;
        else mDrop = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input bit trig, input bit rst);
    logic expStr;
    @(negedge clock);
    trigger = trig;
    reset   = rst;
    @(posedge clock);
    modelStep(trig, rst);
    #1;
    expStr = mActive && ((cycle - mStart) < W);
    checkOutput("stretched", 32'(stretched), 32'(expStr));
    checkOutput("busy", 32'(busy), 32'(mActive || (mPend != 0)));
    checkOutput("pending", 32'(pending), 32'(mPend));
    checkOutput("dropped", 32'(dropped), 32'(mDrop));
    if (stretched === 1'b1 && prevStr === 1'b0) rises++;
    prevStr = stretched;
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    trigger = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("resetStretched", 32'(stretched), 32'd0);
    checkOutput("resetPending", 32'(pending), 32'd0);
    idle(5);

    $display("[TB] single event");
    applyStimulus(1'b1, 1'b0);
    idle(10);

    $display("[TB] queued event");
    applyStimulus(1'b1, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("queuedPending", 32'(pending), 32'd1);
    idle(14);

    $display("[TB] overflow");
    rises = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    idle(25);
    checkOutput("overflowPulses", 32'(rises), 32'd3);

    $display("[TB] direct restart");
    applyStimulus(1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restartStretched", 32'(stretched), 32'd1);
    checkOutput("restartPending", 32'(pending), 32'd0);
    idle(10);

    $display("[TB] simultaneous enqueue and dequeue");
    applyStimulus(1'b1, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0);
    idle(3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("simulPending", 32'(pending), 32'd1);
    checkOutput("simulStretched", 32'(stretched), 32'd1);
    idle(20);

    $display("[TB] reset mid-pulse");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("midResetStretched", 32'(stretched), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetPending", 32'(pending), 32'd0);
    rises = 0;
    idle(20);
    checkOutput("midResetNoPulses", 32'(rises), 32'd0);

    $display("[TB] random stimulus");
    for (int i = 0; i < 2000; i++)
      applyStimulus($urandom_range(99) < 35, $urandom_range(199) == 0);
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
